// File: rtl/digit_tube_capture_if.sv
// Scan bus and decoded display outputs of the 7-segment capture block.
// The master side drives the tube pins; the slave side is the capture logic.
interface digit_tube_capture_if;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic [15:0] val;
  logic [3:0]  dp;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;
  logic        frame;
  logic        stalled;

  modport master (
    output dig, seg,
    input  val, dp, valid, err, upd, frame, stalled
  );

  modport slave (
    input  dig, seg,
    output val, dp, valid, err, upd, frame, stalled
  );
endinterface

// File: rtl/digit_tube_capture.sv
// Samples a multiplexed active-low 7-segment scan bus, filters scan
// transitions and rebuilds the 4-digit hex value with valid/error flags.
module digit_tube_capture #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input logic clk,
  input logic rst,
  digit_tube_capture_if.slave bus
);
  typedef enum logic [1:0] {
    WAIT,
    COUNT,
    CAPTURE,
    HELD
  } state_e;

  localparam logic [11:0] CNT_MAX  = 12'(STABLE_CYCLES);
  localparam logic [11:0] CNT_HIT  = 12'(STABLE_CYCLES - 1);
  localparam logic [23:0] IDLE_TO  = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] IDLE_MAX = 24'hFF_FFFF;

  logic [11:0] s1_q, s2_q;
  logic [11:0] cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic [23:0] idle_q, idle_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] val_q, val_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  err_q, err_d;
  logic        upd_q, upd_d;
  logic        frame_q, frame_d;
  logic        stalled_q, stalled_d;

  logic       chg;
  logic       cap;
  logic [3:0] sel;
  logic [3:0] seen_n;
  logic [4:0] dec;

  function automatic logic [4:0] dec7(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // chg looks one stage ahead so a capture lands STABLE_CYCLES+2 after the pin step
  assign chg = (s1_q != s2_q);
  assign sel = ~s2_q[11:8];
  assign dec = dec7(s2_q[6:0]);

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    if (chg) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 12'd1;
    end
    if (chg) begin
      state_d = WAIT;
    end else begin
      unique case (state_q)
        WAIT:    if ($onehot(sel)) state_d = COUNT;
        COUNT: begin
          if (cnt_q >= CNT_HIT) begin
            state_d = CAPTURE;
            cap     = 1'b1;
          end
        end
        CAPTURE: state_d = HELD;
        HELD:    state_d = HELD;
        default: state_d = WAIT;
      endcase
    end
  end

  always_comb begin
    val_d     = val_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    err_d     = err_q;
    seen_d    = seen_q;
    stalled_d = stalled_q;
    upd_d     = 1'b0;
    frame_d   = 1'b0;
    seen_n    = seen_q | sel;
    idle_d    = (idle_q == IDLE_MAX) ? idle_q : idle_q + 24'd1;
    if (cap) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          dp_d[i]    = ~s2_q[7];
          valid_d[i] = dec[4];
          err_d[i]   = ~dec[4];
          if (dec[4]) val_d[4*i +: 4] = dec[3:0];
        end
      end
      upd_d     = 1'b1;
      idle_d    = '0;
      stalled_d = 1'b0;
      if (seen_n == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_n;
      end
    end else if (idle_d == IDLE_TO) begin
      valid_d   = '0;
      stalled_d = 1'b1;
      seen_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '1;
      s2_q      <= '1;
      cnt_q     <= '0;
      state_q   <= WAIT;
      idle_q    <= '0;
      seen_q    <= '0;
      val_q     <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      frame_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      s1_q      <= {bus.dig, bus.seg};
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      idle_q    <= idle_d;
      seen_q    <= seen_d;
      val_q     <= val_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      frame_q   <= frame_d;
      stalled_q <= stalled_d;
    end
  end

  assign bus.val     = val_q;
  assign bus.dp      = dp_q;
  assign bus.valid   = valid_q;
  assign bus.err     = err_q;
  assign bus.upd     = upd_q;
  assign bus.frame   = frame_q;
  assign bus.stalled = stalled_q;
endmodule

// File: tb/tb_digit_tube_capture.sv
// Randomised and directed bench for digit_tube_capture against a
// sample-run reference model of the scan capture behaviour.
module tb_digit_tube_capture;
  localparam int STB  = 16;
  localparam int TO   = 1000;
  localparam int IMAX = 24'hFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digit_tube_capture_if bus();

  digit_tube_capture #(
    .STABLE_CYCLES (STB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [6:0] pats [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // reference model state
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_valid, m_err, m_seen;
  logic        m_upd, m_frame, m_stalled, m_pend;
  logic [11:0] m_last, m_pv, m_smp;
  int          m_idle, m_run, m_i, m_nib;

  always @(posedge clk) begin
    m_smp = {bus.dig, bus.seg};
    if (rst) begin
      m_val = '0; m_dp = '0; m_valid = '0; m_err = '0; m_seen = '0;
      m_upd = 1'b0; m_frame = 1'b0; m_stalled = 1'b0; m_pend = 1'b0;
      m_idle = 0; m_last = 12'hFFF; m_run = STB + 2; m_pv = '1;
    end else begin
      m_upd = 1'b0;
      m_frame = 1'b0;
      if (m_pend) begin
        m_i = 0;
        for (int j = 0; j < 4; j++) if (!m_pv[8+j]) m_i = j;
        m_nib = -1;
        for (int j = 0; j < 16; j++) if (pats[j] == m_pv[6:0]) m_nib = j;
        m_dp[m_i] = ~m_pv[7];
        if (m_nib >= 0) begin
          m_val[4*m_i +: 4] = 4'(m_nib);
          m_valid[m_i] = 1'b1;
          m_err[m_i] = 1'b0;
        end else begin
          m_valid[m_i] = 1'b0;
          m_err[m_i] = 1'b1;
        end
        m_seen[m_i] = 1'b1;
        if (m_seen == 4'hF) begin
          m_frame = 1'b1;
          m_seen = '0;
        end
        m_upd = 1'b1;
        m_idle = 0;
        m_stalled = 1'b0;
      end else begin
        if (m_idle < IMAX) m_idle++;
        if (m_idle == TO) begin
          m_valid = '0;
          m_stalled = 1'b1;
          m_seen = '0;
        end
      end
      if (m_smp == m_last) begin
        if (m_run < STB + 2) m_run++;
      end else begin
        m_last = m_smp;
        m_run = 1;
      end
      // STB+1 identical pin samples make a dwell; it is captured one edge later
      m_pend = (m_run == STB + 1) && ($countones(~m_last[11:8]) == 1);
      if (m_pend) m_pv = m_last;
    end
  end

  int nchk = 0;
  int nerr = 0;
  int updcnt = 0;
  int frmcnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    logic [30:0] g, e;
    @(negedge clk);
    if (bus.upd === 1'b1) updcnt++;
    if (bus.frame === 1'b1) frmcnt++;
    if (chk_en) begin
      g = {bus.val, bus.dp, bus.valid, bus.err,
           bus.upd, bus.frame, bus.stalled};
      e = {m_val, m_dp, m_valid, m_err, m_upd, m_frame, m_stalled};
      nchk++;
      if (g !== e) begin
        nerr++;
        if (nerr < 30)
          $display("FAIL model t=%0t: got %h expected %h", $time, g, e);
      end
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [3:0] d, input logic [7:0] s);
    bus.dig = d;
    bus.seg = s;
  endtask

  task automatic lat(output int k);
    k = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (bus.upd === 1'b1) begin
        k = n;
        break;
      end
    end
  endtask

  function automatic logic [3:0] dsel(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  logic [7:0] scan [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
  int k, u0, n;

  initial begin
    drive(4'hF, 8'hFF);
    rst = 1'b1;
    wait_n(3);
    chk_en = 1'b1;
    tick();
    chk("reset_val", bus.val, 16'h0);
    chk("reset_flags", {bus.valid, bus.err, bus.dp}, 12'h0);
    chk("reset_pulses", {bus.upd, bus.frame, bus.stalled}, 3'b000);
    rst = 1'b0;
    frmcnt = 0;

    for (int p = 0; p < 2; p++) begin
      for (int d = 0; d < 4; d++) begin
        drive(dsel(d), scan[d]);
        lat(k);
        chk("upd_latency", k, 18);
        wait_n(64 - k);
      end
    end
    chk("scan_val", bus.val, 16'h4321);
    chk("scan_valid", bus.valid, 4'hF);
    chk("scan_err", bus.err, 4'h0);
    chk("scan_frames", frmcnt, 2);

    drive(dsel(0), 8'hF9);
    wait_n(30);
    u0 = updcnt;
    drive(dsel(0), 8'h80);
    wait_n(10);
    chk("glitch_no_upd", updcnt, u0);
    drive(dsel(0), 8'hF9);
    wait_n(40);
    chk("glitch_recapture", updcnt, u0 + 1);
    chk("glitch_val", bus.val, 16'h4321);

    drive(dsel(2), 8'h7F);
    wait_n(30);
    chk("blank_err", {bus.err[2], bus.valid[2]}, 2'b10);
    chk("blank_hold", bus.val[11:8], 4'h3);
    drive(dsel(2), 8'h2B);
    wait_n(30);
    chk("bad_err", {bus.err[2], bus.valid[2]}, 2'b10);
    chk("bad_hold", bus.val[11:8], 4'h3);
    drive(dsel(2), 8'h06);
    wait_n(30);
    chk("e_val", bus.val, 16'h4E21);
    chk("e_flags", {bus.dp[2], bus.err[2], bus.valid[2]}, 3'b101);

    u0 = updcnt;
    drive(4'b1100, 8'h99);
    wait_n(200);
    chk("multi_sel_upd", updcnt, u0);
    chk("multi_sel_out", {bus.val, bus.valid, bus.dp}, {16'h4E21, 4'hF, 4'b0100});
    drive(4'hF, 8'h99);
    wait_n(200);
    chk("no_sel_upd", updcnt, u0);
    chk("no_sel_out", {bus.val, bus.valid, bus.dp}, {16'h4E21, 4'hF, 4'b0100});

    for (int d = 0; d < 3; d++) begin
      drive(dsel(d), scan[d]);
      wait_n(30);
    end
    drive(dsel(3), scan[3]);
    lat(k);
    chk("pre_to_valid", bus.valid, 4'hF);
    chk("pre_to_val", bus.val, 16'h4321);
    n = 0;
    while (bus.stalled !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_valid", bus.valid, 4'h0);
    drive(dsel(1), scan[1]);
    lat(k);
    chk("resume_stalled", bus.stalled, 1'b0);
    chk("resume_valid", bus.valid, 4'b0010);

    drive(dsel(2), scan[2]);
    wait_n(12);
    rst = 1'b1;
    tick();
    chk("midrst_out", {bus.val, bus.dp, bus.valid, bus.err}, 28'h0);
    chk("midrst_pulse", {bus.upd, bus.frame, bus.stalled}, 3'b000);
    rst = 1'b0;
    lat(k);
    chk("midrst_latency_ge18", (k >= 18), 1'b1);

    for (int it = 0; it < 300; it++) begin
      logic [3:0] d;
      logic [7:0] s;
      if ($urandom_range(0, 99) < 4) begin
        rst = 1'b1;
        wait_n($urandom_range(1, 3));
        rst = 1'b0;
      end
      if ($urandom_range(0, 99) < 85) d = dsel($urandom_range(0, 3));
      else d = 4'($urandom);
      if ($urandom_range(0, 99) < 80)
        s = {1'($urandom), pats[$urandom_range(0, 15)]};
      else
        s = 8'($urandom);
      drive(d, s);
      if (it == 150) wait_n(TO + 50);
      else wait_n($urandom_range(1, 40));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/digit_tube_capture.md
Name: digit_tube_capture

Overview:
Receive-side counterpart of the 4-digit multiplexed 7-segment tube driver. It samples the active-low dig[3:0]/seg[7:0] scan bus and filters out scan transitions. It decodes each stable segment pattern back into its hex nibble and decimal-point bit, and presents the reconstructed 4-digit value with per-digit valid/error flags. It is used for board self-test and loopback verification of display drivers.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronized samples required before a dwell is captured (legal range 2..4095)
TIMEOUT_CYCLES, 1048576, cycles without any capture after which all valid bits clear (legal range STABLE_CYCLES+1..2^24-1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
dig  input  4  digit selects, active low; dig[0] low = digit 0 (least significant)
seg  input  8  segments, active low; bit0=a(top), 1=b, 2=c, 3=d, 4=e, 5=f, 6=g(middle), 7=dp
val  output 16  decoded nibbles; val[4i+3:4i] = digit i
dp   output 4  dp[i]=1 when digit i decimal point was lit
valid  output 4  valid[i]=1 when digit i holds a good decode and no timeout has occurred
err  output 4  err[i]=1 when the last capture of digit i was an unrecognised pattern
upd  output 1  one-cycle pulse on every capture
frame  output 1  one-cycle pulse when all four digits have been captured since the last frame pulse
stalled  output 1  high while the timeout is active

Behaviour:
- Sync: dig and seg pass through 2-flop synchronizers. Sync flops reset to all-ones (idle bus). S = second-stage value.
- Stability counter: cnt clears to 0 when S differs from the previous cycle's S. Otherwise it increments, saturating at STABLE_CYCLES.
- Select valid when S.dig has exactly one bit low. Zero or several bits low means blanked: no capture, and the FSM goes to WAIT.
- FSM:
  - WAIT: entered on reset, on a change of S, or on an invalid select.
  - WAIT -> COUNT when the select is valid.
  - COUNT -> CAPTURE when cnt reaches STABLE_CYCLES-1 with S unchanged.
  - CAPTURE lasts one cycle: registers the decode, pulses upd, then goes to HELD.
  - HELD -> WAIT only on a change of S. Each dwell is therefore captured exactly once.
- Latency: with an ideal step on the pins, upd is high on cycle STABLE_CYCLES+2 after the first clk edge that samples the new value. Outputs are registered, and val/dp/valid/err update in the same cycle as upd.
- Decode of seg[6:0] (hex, active low):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
- Any other pattern, including 7F (all off), is an error: err[i]=1, valid[i]=0, val nibble i held.
- On a good decode: nibble i updated, valid[i]=1, err[i]=0.
- dp[i] = ~seg[7] on every capture, good or bad.
- Frame tracking:
  - seen[3:0] sets bit i on each capture of digit i.
  - When the capture makes seen all-ones, frame pulses in the same cycle as upd and seen clears to 0000.
  - A repeat of an already-seen digit does not clear seen.
- Timeout:
  - idle counter (24 bits) clears on each capture and otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES: valid clears to 0000, stalled=1, seen clears. val, dp and err are held.
  - The next capture clears stalled and sets valid for that digit only.
- Reset mid-operation: all outputs 0 on the next edge, FSM in WAIT, cnt/idle/seen cleared. No upd for at least STABLE_CYCLES+2 cycles after rst deasserts.
- Simultaneous events: capture and timeout in the same cycle -> capture wins (idle clears, stalled=0). upd and frame may coincide; frame never asserts without upd.

Test Plan:
1. Scan 1,2,3,4 (dig 1110/C0->F9... i.e. digit0 seg F9, digit1 A4, digit2 B0, digit3 99), dwell 64 cycles each, STABLE_CYCLES=16 -> val=16'h4321, valid=1111, err=0000; upd on cycle 18 of each dwell; frame once per 4-digit pass.
2. Glitch: seg held for 10 cycles mid-dwell, then returns to the original value -> no upd during the glitch, exactly one re-capture afterwards, val unchanged.
3. Digit 2 driven 0x7F (blank) then 0x2B -> err[2]=1, valid[2]=0, val[11:8] retains the prior value. Then 0x80|0x06 (E, dp off)... with seg=0x06 -> val[11:8]=E, dp[2]=1, err[2]=0.
4. dig=1100 (two digits low) for 200 cycles -> no upd, no change on any output. dig=1111 -> same.
5. Stop scanning after valid=1111, TIMEOUT_CYCLES=1000 -> valid=0000 and stalled=1 exactly 1000 cycles after the last upd. Resume -> stalled=0, valid has only the first captured bit set.
6. Assert rst during COUNT (cnt=10) -> all outputs 0 next cycle. First upd after release no earlier than 18 cycles.
